// File: rtl/pll_lock_monitor_if.sv
// Observation interface between the PLL core and its lock monitor.
// The PLL side drives the phase-detector bit, the DCO control word and the
// enable; the monitor side returns lock status and per-window statistics.
interface pll_lock_monitor_if;
  logic       enable;
  logic       lead_lag;
  logic [7:0] lambda;
  logic       lock_det;
  logic       win_done;
  logic [7:0] lambda_span;
  logic [7:0] toggle_cnt;
  logic [1:0] state;

  modport master (
    output enable, lead_lag, lambda,
    input  lock_det, win_done, lambda_span, toggle_cnt, state
  );

  modport slave (
    input  enable, lead_lag, lambda,
    output lock_det, win_done, lambda_span, toggle_cnt, state
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: measures lambda span and lead_lag toggles over fixed
// windows of WIN samples and declares lock after LOCK_WINS consecutive good
// windows. A bad window while locked drops back to ACQUIRE.
module pll_lock_monitor #(
  parameter int WIN       = 64,
  parameter int TOL       = 4,
  parameter int MIN_TOG   = 8,
  parameter int LOCK_WINS = 4
) (
  input  logic             clk_ref,
  input  logic             rst,
  pll_lock_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0] WIN_LAST = 8'(WIN - 1);
  localparam logic [8:0] TOL_L    = 9'(TOL);
  localparam logic [8:0] MIN_L    = 9'(MIN_TOG);
  localparam logic [3:0] LOCK_L   = 4'(LOCK_WINS);

  state_t     state_reg, state_next;
  logic [7:0] wcnt_reg, wcnt_next;
  logic [3:0] good_cnt_reg, good_cnt_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] max_reg, max_next;
  // 9 bits: with WIN = 256 a window can hold 256 toggles
  logic [8:0] tog_reg, tog_next;
  logic       prev_ll_reg, prev_ll_next;
  // Set once the first sample after leaving IDLE has been seen, so that
  // sample never counts as a toggle against a stale prev_ll.
  logic       primed_reg, primed_next;
  logic       lock_det_reg, lock_det_next;
  logic       win_done_reg, win_done_next;
  logic [7:0] span_reg, span_next;
  logic [7:0] tog_out_reg, tog_out_next;

  logic       is_first;
  logic       is_last;
  logic       toggle_now;
  logic [7:0] cur_min, cur_max, win_span;
  logic [8:0] tog_total;
  logic       win_good;

  // Window statistics including the sample presented this cycle
  always_comb begin
    is_first   = (wcnt_reg == 8'd0);
    is_last    = (wcnt_reg == WIN_LAST);
    toggle_now = primed_reg && (mon.lead_lag != prev_ll_reg);
    cur_min    = (is_first || (mon.lambda < min_reg)) ? mon.lambda : min_reg;
    cur_max    = (is_first || (mon.lambda > max_reg)) ? mon.lambda : max_reg;
    win_span   = cur_max - cur_min;
    tog_total  = tog_reg + {8'd0, toggle_now};
    win_good   = ({1'b0, win_span} <= TOL_L) && (tog_total >= MIN_L);
  end

  // Next-state, sampling and window publication
  always_comb begin
    state_next    = state_reg;
    wcnt_next     = wcnt_reg;
    good_cnt_next = good_cnt_reg;
    min_next      = min_reg;
    max_next      = max_reg;
    tog_next      = tog_reg;
    prev_ll_next  = prev_ll_reg;
    primed_next   = primed_reg;
    win_done_next = 1'b0;
    span_next     = span_reg;
    tog_out_next  = tog_out_reg;

    case (state_reg)
      IDLE: begin
        if (mon.enable) begin
          state_next = ACQUIRE;
          wcnt_next  = 8'd0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (!mon.enable) begin
          // Partial window is discarded; published results are kept
          state_next    = IDLE;
          wcnt_next     = 8'd0;
          good_cnt_next = 4'd0;
          min_next      = 8'd0;
          max_next      = 8'd0;
          tog_next      = 9'd0;
          prev_ll_next  = 1'b0;
          primed_next   = 1'b0;
        end else begin
          min_next     = cur_min;
          max_next     = cur_max;
          prev_ll_next = mon.lead_lag;
          primed_next  = 1'b1;
          if (is_last) begin
            wcnt_next     = 8'd0;
            tog_next      = 9'd0;
            win_done_next = 1'b1;
            span_next     = win_span;
            tog_out_next  = tog_total[8] ? 8'hFF : tog_total[7:0];
            if (win_good) begin
              if (state_reg == ACQUIRE) begin
                if (good_cnt_reg + 4'd1 >= LOCK_L) begin
                  good_cnt_next = LOCK_L;
                  state_next    = LOCKED;
                end else begin
                  good_cnt_next = good_cnt_reg + 4'd1;
                end
              end
            end else begin
              good_cnt_next = 4'd0;
              state_next    = ACQUIRE;
            end
          end else begin
            wcnt_next = wcnt_reg + 8'd1;
            tog_next  = tog_total;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    lock_det_next = (state_next == LOCKED);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_reg    <= IDLE;
      wcnt_reg     <= 8'd0;
      good_cnt_reg <= 4'd0;
      min_reg      <= 8'd0;
      max_reg      <= 8'd0;
      tog_reg      <= 9'd0;
      prev_ll_reg  <= 1'b0;
      primed_reg   <= 1'b0;
      lock_det_reg <= 1'b0;
      win_done_reg <= 1'b0;
      span_reg     <= 8'd0;
      tog_out_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wcnt_reg     <= wcnt_next;
      good_cnt_reg <= good_cnt_next;
      min_reg      <= min_next;
      max_reg      <= max_next;
      tog_reg      <= tog_next;
      prev_ll_reg  <= prev_ll_next;
      primed_reg   <= primed_next;
      lock_det_reg <= lock_det_next;
      win_done_reg <= win_done_next;
      span_reg     <= span_next;
      tog_out_reg  <= tog_out_next;
    end
  end

  assign mon.state       = state_reg;
  assign mon.lock_det    = lock_det_reg;
  assign mon.win_done    = win_done_reg;
  assign mon.lambda_span = span_reg;
  assign mon.toggle_cnt  = tog_out_reg;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized scoreboard bench for pll_lock_monitor. A window-level reference
// model predicts the outputs after every clock edge; a monitor process
// compares them and checks each published window against a second queue.
module tb_pll_lock_monitor;
  localparam int WIN       = 64;
  localparam int TOL       = 4;
  localparam int MIN_TOG   = 8;
  localparam int LOCK_WINS = 4;

  logic clk_ref;
  logic rst;
  pll_lock_monitor_if ifc ();

  pll_lock_monitor #(
    .WIN(WIN), .TOL(TOL), .MIN_TOG(MIN_TOG), .LOCK_WINS(LOCK_WINS)
  ) dut (
    .clk_ref(clk_ref),
    .rst    (rst),
    .mon    (ifc)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  typedef struct {
    bit wd;
    int st;
    bit lk;
    int span;
    int tog;
  } exp_t;

  exp_t status_q[$];
  exp_t pub_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_pub    = 0;

  // Reference model state: samples of the window in progress
  int         m_state = 0;
  int         m_good  = 0;
  int         m_span  = 0;
  int         m_tog   = 0;
  int         m_wins  = 0;
  bit         m_have_prev = 0;
  bit         m_carry = 0;
  int         lam_q[$];
  bit         ll_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_clear();
    lam_q.delete();
    ll_q.delete();
    m_have_prev = 0;
  endtask

  // Predict the outputs visible after the edge that consumes these inputs
  task automatic model_step(input bit r, input bit en, input bit ll, input int lam);
    exp_t x;
    int mn, mx, t;
    x.wd = 0;
    if (r) begin
      m_state = 0; m_good = 0; m_span = 0; m_tog = 0; m_wins = 0;
      model_clear();
    end else if (m_state == 0) begin
      if (en) begin
        m_state = 1;
        m_wins  = 0;
      end
      model_clear();
    end else if (!en) begin
      m_state = 0; m_good = 0;
      model_clear();
    end else begin
      lam_q.push_back(lam);
      ll_q.push_back(ll);
      if (lam_q.size() == WIN) begin
        mn = 255; mx = 0; t = 0;
        foreach (lam_q[i]) begin
          if (lam_q[i] < mn) mn = lam_q[i];
          if (lam_q[i] > mx) mx = lam_q[i];
        end
        foreach (ll_q[i]) begin
          if (i == 0) begin
            if (m_have_prev && ll_q[0] != m_carry) t++;
          end else if (ll_q[i] != ll_q[i-1]) begin
            t++;
          end
        end
        m_span = mx - mn;
        m_tog  = (t > 255) ? 255 : t;
        if ((mx - mn) <= TOL && t >= MIN_TOG) begin
          if (m_state == 1) begin
            m_good++;
            if (m_good >= LOCK_WINS) begin
              m_good  = LOCK_WINS;
              m_state = 2;
            end
          end
        end else begin
          m_good  = 0;
          m_state = 1;
        end
        m_carry = ll_q[WIN-1];
        lam_q.delete();
        ll_q.delete();
        m_have_prev = 1;
        m_wins++;
        x.wd = 1;
      end
    end
    x.st   = m_state;
    x.lk   = (m_state == 2);
    x.span = m_span;
    x.tog  = m_tog;
    status_q.push_back(x);
    if (x.wd) pub_q.push_back(x);
  endtask

  task automatic drive(input bit r, input bit en, input bit ll, input int lam);
    @(negedge clk_ref);
    rst          = r;
    ifc.enable   = en;
    ifc.lead_lag = ll;
    ifc.lambda   = 8'(lam);
    model_step(r, en, ll, lam);
  endtask

  // Monitor: compares DUT outputs just after each rising edge
  initial begin
    exp_t s;
    exp_t p;
    forever begin
      @(posedge clk_ref);
      #1;
      if (status_q.size() != 0) begin
        s = status_q.pop_front();
        chk("win_done", {31'd0, ifc.win_done}, {31'd0, s.wd});
        chk("state", {30'd0, ifc.state}, s.st);
        chk("lock_det", {31'd0, ifc.lock_det}, {31'd0, s.lk});
        chk("lambda_span", {24'd0, ifc.lambda_span}, s.span);
        chk("toggle_cnt", {24'd0, ifc.toggle_cnt}, s.tog);
        if (ifc.win_done === 1'b1) begin
          if (pub_q.size() == 0) begin
            chk("unexpected_win_done", 32'd1, 32'd0);
          end else begin
            p = pub_q.pop_front();
            n_pub++;
            chk("pub_span", {24'd0, ifc.lambda_span}, p.span);
            chk("pub_toggles", {24'd0, ifc.toggle_cnt}, p.tog);
            chk("pub_lock", {31'd0, ifc.lock_det}, {31'd0, p.lk});
            $display("window %0d: span=%0d toggles=%0d lock=%0d state=%0d (exp span=%0d toggles=%0d lock=%0d)",
                     n_pub, ifc.lambda_span, ifc.toggle_cnt, ifc.lock_det, ifc.state,
                     p.span, p.tog, p.lk);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit ll;
    int lam;
    int g;
    int jit;
    int prob;
    rst = 1'b1; ifc.enable = 1'b0; ifc.lead_lag = 1'b0; ifc.lambda = 8'd0;

    // Reset then idle with random inputs: nothing may move
    repeat (10) drive(1, 0, 0, 0);
    repeat (100) drive(0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));

    // Clean lock with lambda constant and lead_lag alternating
    ll = 0;
    repeat (6 * WIN) begin ll = ~ll; drive(0, 1, ll, 8'h80); end

    // Drop lock: lead_lag stuck high for more than a window
    repeat (WIN + 5) drive(0, 1, 1, 8'h80);

    // Span failure: lambda steps 0x80 -> 0x85 inside the third window
    drive(0, 0, 0, 8'h80);
    for (int c = 0; c < 9 * WIN + 2; c++) begin
      ll = ~ll;
      lam = (c >= 1 + 2 * WIN + 20) ? 8'h85 : 8'h80;
      drive(0, 1, ll, lam);
    end

    // Enable low at wcnt = 30 while locked, then a fresh acquisition
    g = 0;
    while (!(m_state == 2 && lam_q.size() == 30) && g < 4 * WIN) begin
      ll = ~ll; drive(0, 1, ll, 8'h85); g++;
    end
    if (g >= 4 * WIN) chk("timeout_wait_lock_wcnt30", 32'd0, 32'd1);
    drive(0, 0, ll, 8'h85);
    repeat ($urandom_range(0, 5)) drive(0, 0, 1'($urandom_range(0, 1)), 8'h85);
    repeat (5 * WIN) begin ll = ~ll; drive(0, 1, ll, 8'h85); end

    // Randomized windows: jitter, toggle density and rare enable drops
    for (int w = 0; w < 16; w++) begin
      jit  = $urandom_range(0, 7);
      prob = $urandom_range(0, 100);
      repeat (WIN) begin
        if ($urandom_range(0, 99) < prob) ll = ~ll;
        lam = 8'h70 + $urandom_range(0, jit);
        drive(0, ($urandom_range(0, 299) != 0), ll, lam);
      end
    end

    // Reset in the win_done cycle of the third window, before lock
    drive(0, 0, 0, 8'h80);
    g = 0;
    while (m_wins < 3 && g < 5 * WIN) begin ll = ~ll; drive(0, 1, ll, 8'h80); g++; end
    if (g >= 5 * WIN) chk("timeout_wait_window3", 32'd0, 32'd1);
    drive(1, 1, ll, 8'h80);
    repeat (2 * WIN) begin ll = ~ll; drive(0, 0, ll, 8'h80); end

    // Drain and confirm every prediction was consumed
    repeat (3) @(negedge clk_ref);
    chk("status_q_drained", status_q.size(), 32'd0);
    chk("pub_q_drained", pub_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
